// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared widths, FSM state encoding and helpers for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int WORD_SIZE           = 16;
    localparam int MEM_TIMEOUT_DEFAULT = 64;
    localparam int REG_ADDR_W          = 2;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-status inputs and stage-control outputs exchanged between pipeline and hazard controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_MemRead;
    logic                  mem_B_OP;
    logic                  mem_B_cond;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic                  pc_write;
    logic                  pc_src_branch;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_write;
    logic                  id_ex_flush;
    logic                  ex_mem_write;
    logic                  ex_mem_flush;
    logic [WORD_SIZE-1:0]  stall_cnt;
    logic [WORD_SIZE-1:0]  flush_cnt;
    logic                  mem_timeout;

    // master: the pipeline datapath; slave: the hazard controller.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_MemRead,
               mem_B_OP, mem_B_cond, dmem_req, dmem_ready,
        input  pc_write, pc_src_branch, if_id_write, if_id_flush,
               id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush,
               stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_MemRead,
               mem_B_OP, mem_B_cond, dmem_req, dmem_ready,
        output pc_write, pc_src_branch, if_id_write, if_id_flush,
               id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush,
               stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: an EX load whose destination feeds an ID source.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    output logic                  hazard
);

    logic [REG_ADDR_W-1:0] src_reg [2];
    logic [1:0]            src_used;
    logic [1:0]            src_match;

    assign src_reg[0]  = id_rs;
    assign src_reg[1]  = id_rt;
    assign src_used    = {id_use_rt, id_use_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_reg[gi] == ex_rd);
        end
    endgenerate

    assign hazard = ex_mem_read && (|src_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: memory-freeze FSM with watchdog, priority control mux and perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    hz_state_t            state_reg, state_next;
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_inc;
    logic [WORD_SIZE-1:0] stall_cnt_reg, flush_cnt_reg;
    logic                 mem_timeout_reg;

    logic load_use, freeze, branch_fire;
    logic pc_write, pc_src_branch, if_id_write, if_id_flush;
    logic id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush;

    load_use_detect u_load_use (
        .ex_mem_read (hz.ex_MemRead),
        .ex_rd       (hz.ex_rd),
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_use_rs   (hz.id_use_rs),
        .id_use_rt   (hz.id_use_rt),
        .hazard      (load_use)
    );

    // A MEM_WAIT cycle that sees dmem_ready behaves exactly like RUN.
    assign freeze = ((state_reg == HZ_RUN) && hz.dmem_req && !hz.dmem_ready) ||
                    ((state_reg == HZ_MEM_WAIT) && !hz.dmem_ready);

    always_comb begin
        state_next    = freeze ? HZ_MEM_WAIT : HZ_RUN;
        branch_fire   = 1'b0;
        pc_write      = 1'b1;
        pc_src_branch = 1'b0;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        ex_mem_flush  = 1'b0;
        if (reset) begin
            state_next   = HZ_RUN;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (hz.mem_B_OP && hz.mem_B_cond) begin
            branch_fire   = 1'b1;
            pc_src_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign wait_cnt_inc = (wait_cnt_reg == TIMEOUT_VAL) ? wait_cnt_reg : wait_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= HZ_RUN;
            wait_cnt_reg    <= '0;
            stall_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == HZ_MEM_WAIT && !hz.dmem_ready) begin
                wait_cnt_reg <= wait_cnt_inc;
                if (wait_cnt_inc == TIMEOUT_VAL)
                    mem_timeout_reg <= 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            if (!pc_write)
                stall_cnt_reg <= sat_inc(stall_cnt_reg);
            if (branch_fire)
                flush_cnt_reg <= sat_inc(flush_cnt_reg);
        end
    end

    assign hz.pc_write      = pc_write;
    assign hz.pc_src_branch = pc_src_branch;
    assign hz.if_id_write   = if_id_write;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_write   = id_ex_write;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_write  = ex_mem_write;
    assign hz.ex_mem_flush  = ex_mem_flush;
    assign hz.stall_cnt     = stall_cnt_reg;
    assign hz.flush_cnt     = flush_cnt_reg;
    assign hz.mem_timeout   = mem_timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: control vectors, counters, watchdog and saturation.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Control vector order: pc_write, pc_src_branch, if_id_write, if_id_flush,
    //                       id_ex_write, id_ex_flush, ex_mem_write, ex_mem_flush
    localparam logic [7:0] C_RESET  = 8'b0001_0101;
    localparam logic [7:0] C_FREEZE = 8'b0000_0000;
    localparam logic [7:0] C_BRANCH = 8'b1111_1111;
    localparam logic [7:0] C_LDUSE  = 8'b0000_1110;
    localparam logic [7:0] C_NORMAL = 8'b1010_1010;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    wire [7:0] ctrl = {hz.pc_write, hz.pc_src_branch, hz.if_id_write, hz.if_id_flush,
                       hz.id_ex_write, hz.id_ex_flush, hz.ex_mem_write, hz.ex_mem_flush};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed %h expected %h", vectors, tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] rs, input logic [1:0] rt, input logic urs,
                         input logic urt, input logic [1:0] rd, input logic mr,
                         input logic bop, input logic bcond, input logic req, input logic rdy);
        hz.id_rs = rs;  hz.id_rt = rt;  hz.id_use_rs = urs;  hz.id_use_rt = urt;
        hz.ex_rd = rd;  hz.ex_MemRead = mr;  hz.mem_B_OP = bop;  hz.mem_B_cond = bcond;
        hz.dmem_req = req;  hz.dmem_ready = rdy;
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ctrl0", 16'(ctrl), 16'(C_RESET));
        cycle();
        #1 check("reset_ctrl1", 16'(ctrl), 16'(C_RESET));
        cycle();
        check("reset_stall", hz.stall_cnt, 16'h0000);
        check("reset_flush", hz.flush_cnt, 16'h0000);
        check("reset_tmo", 16'(hz.mem_timeout), 16'h0000);
        reset = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("normal_ctrl", 16'(ctrl), 16'(C_NORMAL));
        cycle();
        check("normal_stall", hz.stall_cnt, 16'h0000);

        // Load-use via rs
        drive(2, 0, 1, 0, 2, 1, 0, 0, 0, 0);
        check("lduse_rs_ctrl", 16'(ctrl), 16'(C_LDUSE));
        cycle();
        check("lduse_rs_stall", hz.stall_cnt, 16'h0001);

        // Load-use via rt
        drive(1, 2, 0, 1, 2, 1, 0, 0, 0, 0);
        check("lduse_rt_ctrl", 16'(ctrl), 16'(C_LDUSE));
        cycle();
        check("lduse_rt_stall", hz.stall_cnt, 16'h0002);

        // Matching register but not read: no hazard
        drive(2, 2, 0, 0, 2, 1, 0, 0, 0, 0);
        check("nouse_ctrl", 16'(ctrl), 16'(C_NORMAL));
        cycle();
        // Read register differs from load destination: no hazard
        drive(2, 1, 1, 1, 3, 1, 0, 0, 0, 0);
        check("nomatch_ctrl", 16'(ctrl), 16'(C_NORMAL));
        cycle();
        check("nohaz_stall", hz.stall_cnt, 16'h0002);

        // Taken branch overrides coincident load-use
        drive(2, 0, 1, 0, 2, 1, 1, 1, 0, 0);
        check("branch_ctrl", 16'(ctrl), 16'(C_BRANCH));
        cycle();
        check("branch_flush", hz.flush_cnt, 16'h0001);
        check("branch_stall", hz.stall_cnt, 16'h0002);

        // Branch not taken: load-use applies, no flush counted
        drive(2, 0, 1, 0, 2, 1, 1, 0, 0, 0);
        check("ntaken_ctrl", 16'(ctrl), 16'(C_LDUSE));
        cycle();
        check("ntaken_flush", hz.flush_cnt, 16'h0001);
        check("ntaken_stall", hz.stall_cnt, 16'h0003);

        // Memory wait: three frozen cycles then ready
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            check($sformatf("memwait_ctrl%0d", i), 16'(ctrl), 16'(C_FREEZE));
            cycle();
        end
        check("memwait_stall", hz.stall_cnt, 16'h0006);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("memready_ctrl", 16'(ctrl), 16'(C_NORMAL));
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("back_run_ctrl", 16'(ctrl), 16'(C_NORMAL));
        cycle();
        check("memready_stall", hz.stall_cnt, 16'h0006);

        // Branch deferred by freeze, then fires on the ready cycle
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        check("defer_ctrl", 16'(ctrl), 16'(C_FREEZE));
        cycle();
        check("defer_flush", hz.flush_cnt, 16'h0001);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        check("defer_fire_ctrl", 16'(ctrl), 16'(C_BRANCH));
        cycle();
        check("defer_fire_flush", hz.flush_cnt, 16'h0002);
        check("defer_stall", hz.stall_cnt, 16'h0007);

        // Watchdog: one RUN freeze cycle, then MEM_WAIT cycles 1..5
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle();
            check($sformatf("tmo_after%0d", i), 16'(hz.mem_timeout), (i >= 4) ? 16'h0001 : 16'h0000);
        end
        check("tmo_stall", hz.stall_cnt, 16'h000D);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("tmo_ready_ctrl", 16'(ctrl), 16'(C_NORMAL));
        cycle();
        check("tmo_sticky", 16'(hz.mem_timeout), 16'h0001);

        // Reset in the middle of a wait
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        cycle();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("midrst_ctrl", 16'(ctrl), 16'(C_RESET));
        cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("midrst_run_ctrl", 16'(ctrl), 16'(C_NORMAL));
        check("midrst_tmo", 16'(hz.mem_timeout), 16'h0000);
        check("midrst_stall", hz.stall_cnt, 16'h0000);
        check("midrst_flush", hz.flush_cnt, 16'h0000);
        cycle();

        // Saturation: stall until 16'hFFFE, then three more stalls
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (16'hFFFE) cycle();
        check("sat_pre", hz.stall_cnt, 16'hFFFE);
        repeat (3) cycle();
        check("sat_hold", hz.stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
